// File: rtl/fpmul_issue.sv
// fpmul_issue: issue/capture stage around a combinational FP multiplier.
// Operands are accepted over valid/ready, parked on the multiplier inputs
// for SETTLE cycles, then the product and flags are registered and offered
// downstream over valid/ready. Sticky flags accumulate the flags of every
// delivered result until cleared.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         operand handshake; in_a, in_b, in_control
//   mul_a/mul_b/mul_control   registered operands driven to the multiplier
//   mul_y/mul_flags           multiplier product and flags
//   out_valid/out_ready       result handshake; out_y, out_flags
//   sticky_flags/sticky_clr   accumulated flags and their synchronous clear
//   busy                      state is not IDLE
//
// state     | meaning
// ST_IDLE   | waiting for an operand pair
// ST_SETTLE | operands held on multiplier, counting down settle window
// ST_HOLD   | result registered and offered downstream
module fpmul_issue #(
  parameter int WIDTH    = 32,
  parameter int WFLAG    = 5,
  parameter int WCONTROL = 5,
  parameter int SETTLE   = 3,
  parameter int WCNT     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [WCONTROL-1:0] in_control,
  output logic [WIDTH-1:0]    mul_a,
  output logic [WIDTH-1:0]    mul_b,
  output logic [WCONTROL-1:0] mul_control,
  input  logic [WIDTH-1:0]    mul_y,
  input  logic [WFLAG-1:0]    mul_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_y,
  output logic [WFLAG-1:0]    out_flags,
  output logic [WFLAG-1:0]    sticky_flags,
  input  logic                sticky_clr,
  output logic                busy
);

  if (SETTLE < 1 || SETTLE > 15 || (2 ** WCNT) <= SETTLE) begin : g_param_check
    $error("fpmul_issue: SETTLE must be 1..15 and representable in WCNT bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WCNT-1:0] r_count;
  logic            w_accept;
  logic            w_xfer;
  logic            w_capture;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_count == '0) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // Ready passes through so a new pair can enter on the transfer edge.
        in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? ST_SETTLE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = (r_state == ST_HOLD) & out_ready;
  assign w_capture = (r_state == ST_SETTLE) & (r_count == '0);
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_control  <= '0;
      out_y        <= '0;
      out_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        mul_a       <= in_a;
        mul_b       <= in_b;
        mul_control <= in_control;
        r_count     <= WCNT'(SETTLE - 1);
      end else if ((r_state == ST_SETTLE) && (r_count != '0)) begin
        r_count <= r_count - WCNT'(1);
      end

      if (w_capture) begin
        out_y     <= mul_y;
        out_flags <= mul_flags;
      end

      // A clear coinciding with a transfer keeps the delivered result's flags.
      if (w_xfer) begin
        sticky_flags <= sticky_clr ? out_flags : (sticky_flags | out_flags);
      end else if (sticky_clr) begin
        sticky_flags <= '0;
      end
    end
  end

endmodule
